dma_copy_engine: RTL and testbench

//  Descriptor-driven memory-to-memory copy engine driving the DMA requester port of the

---
 rtl/dma_copy_engine.sv | 181 ++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_copy_engine : descriptor-driven chunked memory-to-memory copy engine
// Revision 1.0
// ----------------------------------------------------------------------------
module dma_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int BURST      = 4,
  parameter int ADDR_INC   = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);
  localparam int IDX_W   = $clog2(BURST);
  localparam int CHUNK_W = IDX_W + 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t r_state, w_nextState;

  logic [ADDR_WIDTH-1:0] r_src, r_dst, r_memAddr;
  logic [LEN_WIDTH-1:0]  r_remaining, r_wordsDone;
  logic [IDX_W-1:0]      r_idx;
  logic [WD_W-1:0]       r_watchdog;
  logic                  r_busy, r_done, r_err, r_memEn, r_memWrEn;
  logic [DATA_WIDTH-1:0] r_memWdata;
  logic [DATA_WIDTH-1:0] r_buffer [BURST];

  logic [CHUNK_W-1:0]    w_chunk;
  logic                  w_accept, w_handshake, w_timeout, w_kill, w_lastWord;
  logic [ADDR_WIDTH-1:0] w_wordOffset, w_chunkOffset;

  assign w_chunk       = (r_remaining >= LEN_WIDTH'(BURST)) ? CHUNK_W'(BURST)
                                                            : r_remaining[CHUNK_W-1:0];
  // A done pulse still high in IDLE blocks a coincident start.
  assign w_accept      = (r_state == S_IDLE) && start && !r_done;
  assign w_handshake   = r_memEn && mem_valid;
  assign w_timeout     = r_memEn && !mem_valid && (r_watchdog == WD_W'(TIMEOUT - 1));
  assign w_kill        = abort || w_timeout;
  assign w_lastWord    = ({1'b0, r_idx} == (w_chunk - CHUNK_W'(1)));
  assign w_wordOffset  = ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(ADDR_INC);
  assign w_chunkOffset = ADDR_WIDTH'(w_chunk) * ADDR_WIDTH'(ADDR_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = (xfer_len == '0) ? S_FIN : S_READ;
      S_READ: begin
        if (w_kill)                          w_nextState = S_ERR;
        else if (w_handshake && w_lastWord)  w_nextState = S_WRITE;
      end
      S_WRITE: begin
        if (w_kill)                          w_nextState = S_ERR;
        else if (w_handshake && w_lastWord)
          w_nextState = (r_remaining == LEN_WIDTH'(w_chunk)) ? S_FIN : S_READ;
      end
      S_FIN:   w_nextState = abort ? S_ERR : S_IDLE;
      S_ERR:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_wordsDone <= '0;
      r_idx       <= '0;
      r_watchdog  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_memEn     <= 1'b0;
      r_memWrEn   <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src       <= src_addr;
            r_dst       <= dst_addr;
            r_remaining <= xfer_len;
            r_wordsDone <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_idx       <= '0;
            r_watchdog  <= '0;
          end
        end
        S_READ, S_WRITE: begin
          if (w_kill) begin
            r_memEn    <= 1'b0;
            r_memWrEn  <= 1'b0;
            r_watchdog <= '0;
          end else if (w_handshake) begin
            // Dropping mem_en here creates the mandatory gap cycle.
            r_memEn    <= 1'b0;
            r_memWrEn  <= 1'b0;
            r_watchdog <= '0;
            r_idx      <= w_lastWord ? '0 : r_idx + IDX_W'(1);
            if (r_state == S_WRITE) begin
              r_wordsDone <= r_wordsDone + LEN_WIDTH'(1);
              if (w_lastWord) begin
                r_remaining <= r_remaining - LEN_WIDTH'(w_chunk);
                r_src       <= r_src + w_chunkOffset;
                r_dst       <= r_dst + w_chunkOffset;
              end
            end
          end else if (r_memEn) begin
            r_watchdog <= r_watchdog + WD_W'(1);
          end else begin
            r_memEn   <= 1'b1;
            r_memWrEn <= (r_state == S_WRITE);
            r_memAddr <= ((r_state == S_WRITE) ? r_dst : r_src) + w_wordOffset;
            if (r_state == S_WRITE) r_memWdata <= r_buffer[r_idx];
          end
        end
        S_FIN: begin
          if (!abort) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_ERR: begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_READ) && w_handshake && !abort) r_buffer[r_idx] <= mem_rdata;
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign words_done = r_wordsDone;
  assign mem_en     = r_memEn;
  assign mem_wr_en  = r_memWrEn;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dma_copy_engine : scoreboard bench with a responding memory model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_dma_copy_engine;
  localparam int DW = 32, AW = 32, LW = 16, BURST = 4, ADDR_INC = 1, TIMEOUT = 64;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [LW-1:0] xfer_len = '0;
  logic          busy, done, err, mem_en, mem_wr_en;
  logic [LW-1:0] words_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;

  dma_copy_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .BURST(BURST), .ADDR_INC(ADDR_INC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  acc_t expQ[$];
  int   checks = 0, passes = 0;
  int   respDelay = 1, waitCnt = 0, hsCount = 0, enCycles = 0;
  bit   holding = 1'b0, prevValid = 1'b0;
  acc_t held, cur, expAcc;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Reference: copy split into chunks of up to BURST words, each read then written.
  task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len);
    acc_t a;
    for (int off = 0; off < len; off += BURST) begin
      int n;
      n = (len - off < BURST) ? (len - off) : BURST;
      for (int i = 0; i < n; i++) begin
        a.wr = 1'b0; a.addr = s + AW'((off + i) * ADDR_INC); a.data = '0;
        expQ.push_back(a);
      end
      for (int i = 0; i < n; i++) begin
        a.wr = 1'b1; a.addr = d + AW'((off + i) * ADDR_INC);
        a.data = model_data(s + AW'((off + i) * ADDR_INC));
        expQ.push_back(a);
      end
    end
  endtask

  // Memory responder and monitor: answers after respDelay cycles, scores each access.
  always @(negedge clk) begin
    if (prevValid) check(!mem_en, "gap_after_access", mem_en, 0);
    prevValid = 1'b0;
    if (!rst_n || !mem_en) begin
      mem_valid = 1'b0;
      waitCnt   = 0;
      holding   = 1'b0;
    end else begin
      enCycles++;
      cur = {mem_wr_en, mem_addr, mem_wdata};
      if (!holding) begin
        holding = 1'b1;
        held    = cur;
      end
      if (respDelay >= 0 && waitCnt >= respDelay) begin
        mem_valid = 1'b1;
        prevValid = 1'b1;
        mem_rdata = mem_wr_en ? DW'($urandom) : model_data(mem_addr);
        hsCount++;
        if (waitCnt > 0)
          check(cur == held, "req_stable", {cur.addr, cur.data}, {held.addr, held.data});
        if (expQ.size() == 0) begin
          check(1'b0, "unexpected_access", {31'd0, mem_wr_en, mem_addr}, 0);
        end else begin
          expAcc = expQ.pop_front();
          check(mem_wr_en == expAcc.wr && mem_addr == expAcc.addr &&
                (!expAcc.wr || mem_wdata == expAcc.data),
                mem_wr_en ? "write_access" : "read_access",
                {mem_addr, mem_wdata}, {expAcc.addr, expAcc.data});
        end
        waitCnt = 0;
        holding = 1'b0;
      end else begin
        mem_valid = 1'b0;
        waitCnt++;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; xfer_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_xfer(input bit expErr, input int expWords);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "done_seen", ok, 1);
    if (ok) begin
      check(err == expErr, "err_flag", err, expErr);
      check(words_done == LW'(expWords), "words_done", words_done, expWords);
      check(!mem_en, "mem_en_at_done", mem_en, 0);
      @(negedge clk);
      check(!done && !busy, "done_pulse_busy_clear", {done, busy}, 0);
    end
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len,
                          input int dly, input bit midStart);
    respDelay = dly;
    push_copy(s, d, len);
    do_start(s, d, LW'(len));
    check(busy && !err, "busy_after_start", {busy, err}, 2);
    if (midStart) begin
      @(negedge clk);
      src_addr = ~s; dst_addr = ~d; xfer_len = 1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    finish_xfer(1'b0, len);
    check(expQ.size() == 0, "all_accesses_seen", expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    int base, target;
    bit ok;
    logic [AW-1:0] s;
    repeat (3) @(negedge clk);
    check(!busy && !done && !err, "reset_status", {busy, done, err}, 0);
    check(!mem_en && !mem_wr_en && mem_addr == 0 && mem_wdata == 0, "reset_mem_port",
          {mem_en, mem_wr_en, mem_addr}, 0);
    check(words_done == 0, "reset_words_done", words_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_copy(32'h100, 32'h200, 3, 1, 1'b0);
    run_copy(32'h1000, 32'h3000, 10, 1, 1'b0);

    // Zero-length transfer, then a start coinciding with its done pulse.
    base = enCycles;
    do_start(32'h40, 32'h80, 0);
    check(busy && !done, "len0_busy_cycle", {busy, done}, 2);
    @(negedge clk);
    check(done && !busy, "len0_done_cycle", {done, busy}, 2);
    src_addr = 32'h900; dst_addr = 32'hA00; xfer_len = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(!busy, "start_during_done_ignored", busy, 0);
    repeat (6) @(negedge clk);
    check(enCycles == base, "len0_no_access", enCycles - base, 0);

    run_copy(32'h2000, 32'h2800, 6, 5, 1'b0);

    // Grant never returned.
    respDelay = -1;
    base = enCycles;
    do_start(32'h300, 32'h400, 3);
    finish_xfer(1'b1, 0);
    check(enCycles - base == TIMEOUT, "timeout_wait_cycles", enCycles - base, TIMEOUT);
    expQ.delete();

    run_copy(32'h500, 32'h600, 2, 1, 1'b0);

    // Abort in the middle of the second chunk's writes (after 2 of its 4 writes).
    respDelay = 2;
    push_copy(32'h7000, 32'h7100, 10);
    target = hsCount + 14;
    do_start(32'h7000, 32'h7100, 10);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (hsCount >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "abort_point_reached", hsCount, target);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    finish_xfer(1'b1, 6);
    expQ.delete();

    run_copy(32'hFFFF_FFFE, 32'h5000, 4, 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      s = $urandom;
      run_copy(s, $urandom, $urandom_range(4, 20), $urandom_range(0, 3), 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d checks, expected run to complete", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
